// File: rtl/regf_mp_sb_pkg.sv
// Shared defaults for the NPC integer register file: core widths and architectural indices.
package regf_mp_sb_pkg;

   localparam int unsigned CPU_WIDTH = 32;
   localparam int unsigned REG_NUM   = 16;
   localparam int unsigned REG_AW    = $clog2(REG_NUM);
   localparam int unsigned RD_PORTS  = 2;
   localparam int unsigned WR_PORTS  = 2;
   localparam int unsigned A0_IDX    = 10;

endpackage

// File: rtl/regf_fwd_sel.sv
// Write-port match for one register address: hit flag and the winning (highest-index) data.
module regf_fwd_sel #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 4,
   parameter int unsigned NWR  = 2
) (
   input  logic [AW-1:0]       addr,
   input  logic [NWR-1:0]      wen,
   input  logic [NWR*AW-1:0]   waddr,
   input  logic [NWR*XLEN-1:0] wdata,
   output logic                hit_c,
   output logic [XLEN-1:0]     data_c
);

   // Later ports overwrite earlier matches, giving the highest index priority; x0 never hits.
   always_comb begin
      hit_c  = 1'b0;
      data_c = '0;
      for (int w = 0; w < NWR; w++) begin
         if (wen[w] && (waddr[w*AW +: AW] == addr)) begin
            hit_c  = 1'b1;
            data_c = wdata[w*XLEN +: XLEN];
         end
      end
      if (addr == '0) begin
         hit_c  = 1'b0;
         data_c = '0;
      end
   end

endmodule

// File: rtl/regf_mp_sb.sv
// Multi-port integer register file with optional write->read bypass and a busy scoreboard.
module regf_mp_sb
   import regf_mp_sb_pkg::*;
#(
   parameter  int unsigned XLEN   = CPU_WIDTH,
   parameter  int unsigned NREG   = REG_NUM,
   parameter  int unsigned NRD    = RD_PORTS,
   parameter  int unsigned NWR    = WR_PORTS,
   parameter  int unsigned BYPASS = 1,
   localparam int unsigned AW     = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*XLEN-1:0]  rdata,
   output logic [NRD-1:0]       rbusy,
   input  logic [NWR-1:0]       wen,
   input  logic [NWR*AW-1:0]    waddr,
   input  logic [NWR*XLEN-1:0]  wdata,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_rd,
   input  logic                 flush,
   output logic                 s_a0zero,
   output logic [NREG*XLEN-1:0] flat_rf
);

   localparam bit BYP  = (BYPASS != 0);
   localparam bit POW2 = (NREG == (32'd1 << AW));

   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   logic [NREG-1:1] wr_hit;
   logic [XLEN-1:0] wr_data [1:NREG-1];
   logic [NRD-1:0]  rd_hit;
   logic [XLEN-1:0] rd_fdata [NRD];
   logic [NRD-1:0]  rd_ok;

   // Per-register write select: enable and priority-muxed data
   for (genvar r = 1; r < NREG; r++) begin : g_wsel
      regf_fwd_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_wsel (
         .addr   (AW'(r)),
         .wen    (wen),
         .waddr  (waddr),
         .wdata  (wdata),
         .hit_c  (wr_hit[r]),
         .data_c (wr_data[r])
      );
   end

   // Per-read-port forwarding lookup and address range check
   for (genvar p = 0; p < NRD; p++) begin : g_rsel
      regf_fwd_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_rsel (
         .addr   (raddr[p*AW +: AW]),
         .wen    (wen),
         .waddr  (waddr),
         .wdata  (wdata),
         .hit_c  (rd_hit[p]),
         .data_c (rd_fdata[p])
      );
      if (POW2) begin : g_full
         assign rd_ok[p] = 1'b1;
      end else begin : g_part
         assign rd_ok[p] = (32'(raddr[p*AW +: AW]) < NREG);
      end
   end

   // Next-state for storage and scoreboard; flush beats issue beats writeback
   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NREG; r++) begin
         rf_d[r] = rf_q[r];
      end
      rf_d[0]   = '0;
      busy_d[0] = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         if (wr_hit[r]) begin
            rf_d[r] = wr_data[r];
         end
         if (flush) begin
            busy_d[r] = 1'b0;
         end else if (iss_en && (iss_rd == AW'(r))) begin
            busy_d[r] = 1'b1;
         end else if (wr_hit[r]) begin
            busy_d[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            rf_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            rf_q[r] <= rf_d[r];
         end
         busy_q <= busy_d;
      end
   end

   // Asynchronous read ports; a same-cycle writeback also clears the hazard when bypassing
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int p = 0; p < NRD; p++) begin
         if (rd_ok[p] && (raddr[p*AW +: AW] != '0)) begin
            if (BYP && rd_hit[p]) begin
               rdata[p*XLEN +: XLEN] = rd_fdata[p];
            end else begin
               rdata[p*XLEN +: XLEN] = rf_q[raddr[p*AW +: AW]];
            end
            rbusy[p] = busy_q[raddr[p*AW +: AW]] && !(BYP && rd_hit[p]);
         end
      end
   end

   if (NREG > A0_IDX) begin : g_a0
      assign s_a0zero = (rf_q[A0_IDX] == '0);
   end else begin : g_no_a0
      assign s_a0zero = 1'b1;
   end

   for (genvar r = 0; r < NREG; r++) begin : g_flat
      assign flat_rf[r*XLEN +: XLEN] = rf_q[r];
   end

endmodule

// File: tb/tb_regf_mp_sb.sv
// Directed bench for regf_mp_sb: one bypassing and one non-bypassing instance on shared inputs.
module tb_regf_mp_sb;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   raddr;
   logic [63:0]  rdata_b, rdata_n;
   logic [1:0]   rbusy_b, rbusy_n;
   logic [1:0]   wen;
   logic [7:0]   waddr;
   logic [63:0]  wdata;
   logic         iss_en;
   logic [3:0]   iss_rd;
   logic         flush;
   logic         a0z_b, a0z_n;
   logic [511:0] flat_b, flat_n;

   int errors = 0;
   int checks = 0;
   logic [31:0] mdl [16];

   always #5 clk = ~clk;

   regf_mp_sb #(.BYPASS(1)) u_dut_b (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
      .wen(wen), .waddr(waddr), .wdata(wdata), .iss_en(iss_en), .iss_rd(iss_rd),
      .flush(flush), .s_a0zero(a0z_b), .flat_rf(flat_b)
   );

   regf_mp_sb #(.BYPASS(0)) u_dut_n (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
      .wen(wen), .waddr(waddr), .wdata(wdata), .iss_en(iss_en), .iss_rd(iss_rd),
      .flush(flush), .s_a0zero(a0z_n), .flat_rf(flat_n)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input int w, input logic en, input logic [3:0] a, input logic [31:0] d);
      wen[w]          = en;
      waddr[w*4 +: 4] = a;
      wdata[w*32 +: 32] = d;
   endtask

   task automatic idle();
      wen    = 2'b00;
      iss_en = 1'b0;
      flush  = 1'b0;
   endtask

   initial begin
      // Reset held with every write port and an issue active
      rst = 1'b1; iss_en = 1'b1; iss_rd = 4'd3; flush = 1'b0;
      set_w(0, 1'b1, 4'd5, 32'hFFFF_FFFF);
      set_w(1, 1'b1, 4'd10, 32'hFFFF_FFFF);
      raddr = {4'd10, 4'd5};
      tick(); tick();
      rst = 1'b0; idle();
      #1;
      chk("rst_rd0", rdata_b[31:0], 32'h0);
      chk("rst_rd1", rdata_b[63:32], 32'h0);
      chk("rst_busy", 32'(rbusy_b), 32'h0);
      raddr = {4'd0, 4'd3};
      #1;
      chk("rst_busy_iss", 32'(rbusy_b), 32'h0);
      chk("rst_a0z", 32'(a0z_b), 32'h1);

      // Same-address writes: port 1 wins
      set_w(0, 1'b1, 4'd5, 32'h11);
      set_w(1, 1'b1, 4'd5, 32'h22);
      tick(); idle();
      raddr = {4'd0, 4'd5};
      #1;
      chk("prio_x5", rdata_b[31:0], 32'h22);
      chk("prio_x0", rdata_b[63:32], 32'h0);
      chk("flat_x5", flat_b[5*32 +: 32], 32'h22);

      // x0 writes dropped, not forwarded
      set_w(0, 1'b1, 4'd0, 32'hDEAD);
      raddr = {4'd0, 4'd0};
      #1;
      chk("x0_byp", rdata_b[31:0], 32'h0);
      tick(); idle();
      #1;
      chk("x0_after", rdata_b[31:0], 32'h0);
      chk("x0_flat", flat_b[31:0], 32'h0);

      // Bypass vs. registered visibility
      set_w(0, 1'b1, 4'd3, 32'hABCD);
      raddr = {4'd0, 4'd3};
      #1;
      chk("byp_same", rdata_b[31:0], 32'hABCD);
      chk("nobyp_same", rdata_n[31:0], 32'h0);
      tick(); idle();
      #1;
      chk("nobyp_next", rdata_n[31:0], 32'hABCD);

      // Scoreboard: issue then writeback
      iss_en = 1'b1; iss_rd = 4'd7;
      raddr = {4'd7, 4'd3};
      #1;
      chk("iss_same", 32'(rbusy_b[1]), 32'h0);
      tick(); idle();
      #1;
      chk("iss_next_b", 32'(rbusy_b[1]), 32'h1);
      chk("iss_next_n", 32'(rbusy_n[1]), 32'h1);
      set_w(0, 1'b1, 4'd7, 32'h77);
      #1;
      chk("wb_byp_busy", 32'(rbusy_b[1]), 32'h0);
      chk("wb_nobyp_busy", 32'(rbusy_n[1]), 32'h1);
      chk("wb_byp_data", rdata_b[63:32], 32'h77);
      tick(); idle();
      #1;
      chk("wb_after_b", 32'(rbusy_b[1]), 32'h0);
      chk("wb_after_n", 32'(rbusy_n[1]), 32'h0);

      // Issue and writeback together: new producer wins
      iss_en = 1'b1; iss_rd = 4'd7;
      set_w(1, 1'b1, 4'd7, 32'h78);
      tick(); idle();
      #1;
      chk("iss_wb_b", 32'(rbusy_b[1]), 32'h1);
      chk("iss_wb_n", 32'(rbusy_n[1]), 32'h1);
      chk("iss_wb_data", rdata_n[63:32], 32'h78);

      // Flush beats a same-cycle issue
      flush = 1'b1; iss_en = 1'b1; iss_rd = 4'd9;
      raddr = {4'd7, 4'd9};
      #1;
      chk("flush_same", 32'(rbusy_b[1]), 32'h1);
      tick(); idle();
      #1;
      chk("flush_after", 32'(rbusy_b), 32'h0);

      // a0 zero flag follows stored x10
      set_w(0, 1'b1, 4'd10, 32'h0);
      tick(); idle();
      #1;
      chk("a0_zero", 32'(a0z_b), 32'h1);
      set_w(0, 1'b1, 4'd10, 32'h1);
      #1;
      chk("a0_nobyp", 32'(a0z_b), 32'h1);
      tick(); idle();
      #1;
      chk("a0_one", 32'(a0z_b), 32'h0);
      set_w(1, 1'b1, 4'd10, 32'h0);
      tick(); idle();
      #1;
      chk("a0_back", 32'(a0z_n), 32'h1);

      // Randomised multi-port traffic against a reference array
      for (int r = 0; r < 16; r++) mdl[r] = 32'h0;
      for (int r = 1; r < 16; r++) mdl[r] = flat_n[r*32 +: 32];
      mdl[3] = 32'hABCD; mdl[5] = 32'h22; mdl[7] = 32'h78; mdl[10] = 32'h0;
      for (int c = 0; c < 2000; c++) begin
         logic [31:0] exp_b;
         logic [3:0]  ra;
         wen   = 2'($urandom_range(0, 3));
         waddr = 8'($urandom);
         wdata = {32'($urandom), 32'($urandom)};
         raddr = 8'($urandom);
         #1;
         for (int p = 0; p < 2; p++) begin
            ra = raddr[p*4 +: 4];
            exp_b = mdl[ra];
            for (int w = 0; w < 2; w++) begin
               if (wen[w] && waddr[w*4 +: 4] == ra && ra != 4'd0) exp_b = wdata[w*32 +: 32];
            end
            chk("rnd_byp", rdata_b[p*32 +: 32], exp_b);
            chk("rnd_nobyp", rdata_n[p*32 +: 32], mdl[ra]);
         end
         tick();
         for (int w = 0; w < 2; w++) begin
            if (wen[w] && waddr[w*4 +: 4] != 4'd0) mdl[waddr[w*4 +: 4]] = wdata[w*32 +: 32];
         end
      end
      idle();
      #1;
      chk("rnd_a0z", 32'(a0z_b), 32'(mdl[10] == 32'h0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
